// File: rtl/csa_fan_pkg.sv
// Shared types and default widths for the carry-save FAN datapath
// (accumulator and downstream Kogge-Stone adder stage).
package csa_fan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } acc_state_e;

    localparam int unsigned N_DEFAULT     = 16;
    localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/csa_3to2.sv
// Single-level 3:2 carry-save compressor; carry vector is pre-shifted
// and truncated to N bits so the MSB carry-out is dropped (mod 2^N).
module csa_3to2
    import csa_fan_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] s,
    output logic [N-1:0] cy
);

    logic [N-1:0] maj;

    always_comb begin
        s   = a ^ b ^ c;
        maj = (a & b) | (a & c) | (b & c);
        cy  = {maj[N-2:0], 1'b0};
    end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming carry-save accumulator: folds each accepted beat into a
// redundant (sum, carry) pair and presents the result on a valid/ready port.
module csa_stream_accumulator
    import csa_fan_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic [N-1:0]     out_carry,
    output logic [CNT_W-1:0] out_count
);

    acc_state_e       state;
    acc_state_e       state_next;
    logic [N-1:0]     sum_q;
    logic [N-1:0]     carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     sum_d;
    logic [N-1:0]     carry_d;
    logic             in_fire;
    logic             out_fire;

    csa_3to2 #(
        .N (N)
    ) u_csa (
        .a  (sum_q),
        .b  (carry_q),
        .c  (in_data),
        .s  (sum_d),
        .cy (carry_d)
    );

    always_comb begin
        in_ready   = (state != HOLD);
        out_valid  = (state == HOLD);
        in_fire    = in_valid & in_ready;
        out_fire   = out_valid & out_ready;
        state_next = state;
        case (state)
            IDLE, ACC: begin
                if (in_fire) begin
                    state_next = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                // Saturate rather than wrap so long packets report the ceiling.
                cnt_q   <= (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end else if (out_fire) begin
                sum_q   <= '0;
                carry_q <= '0;
                cnt_q   <= '0;
            end
        end
    end

    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed self-checking bench for csa_stream_accumulator (default widths
// plus a CNT_W=2 instance for counter saturation).
module tb_csa_stream_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [15:0] out_carry;
    logic [7:0]  out_count;

    logic        in_valid2;
    logic        in_ready2;
    logic [15:0] in_data2;
    logic        in_last2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] out_sum2;
    logic [15:0] out_carry2;
    logic [1:0]  out_count2;

    int checks = 0;
    int errors = 0;

    csa_stream_accumulator #(
        .N     (16),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    csa_stream_accumulator #(
        .N     (16),
        .CNT_W (2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .in_last   (in_last2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_sum   (out_sum2),
        .out_carry (out_carry2),
        .out_count (out_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one beat on the default-width instance and waits (bounded) for acceptance.
    task automatic send_beat(input logic [15:0] d, input logic last);
        bit ok;
        bit rdy;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: data=%h not accepted within 20 cycles, required acceptance", d);
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = '0;
        in_last2   = 1'b0;
        out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_handshake: in_ready/out_valid=%b required 10", {in_ready, out_valid});
        end
        checks++;
        if ({out_sum, out_carry, out_count} !== 40'h0) begin
            errors++;
            $display("FAIL reset_regs: sum=%h carry=%h count=%0d required 0/0/0", out_sum, out_carry, out_count);
        end
    endtask

    task automatic test_basic_packet;
        out_ready = 1'b1;
        send_beat(16'd3, 1'b0);
        send_beat(16'd5, 1'b0);
        send_beat(16'd7, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        checks++;
        if (out_sum !== 16'd3 || out_carry !== 16'd12) begin
            errors++;
            $display("FAIL basic_pair: sum=%h carry=%h required 0003/000c", out_sum, out_carry);
        end
        checks++;
        if (16'(out_sum + out_carry) !== 16'd15 || out_count !== 8'd3) begin
            errors++;
            $display("FAIL basic_total: total=%0d count=%0d required 15/3", 16'(out_sum + out_carry), out_count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0 || out_count !== 8'd0) begin
            errors++;
            $display("FAIL basic_release: in_ready=%b out_valid=%b sum=%h count=%0d required 1/0/0/0",
                     in_ready, out_valid, out_sum, out_count);
        end
    endtask

    task automatic test_single_beat;
        out_ready = 1'b1;
        send_beat(16'hBEEF, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'hBEEF || out_carry !== 16'h0 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL single_beat: valid=%b sum=%h carry=%h count=%0d required 1/beef/0000/1",
                     out_valid, out_sum, out_carry, out_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wraparound;
        out_ready = 1'b1;
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'h0001, 1'b0);
        send_beat(16'h8000, 1'b0);
        send_beat(16'h8000, 1'b1);
        checks++;
        if (out_sum !== 16'hFFF8 || out_carry !== 16'h0008) begin
            errors++;
            $display("FAIL wrap_pair: sum=%h carry=%h required fff8/0008", out_sum, out_carry);
        end
        checks++;
        if (16'(out_sum + out_carry) !== 16'h0000 || out_count !== 8'd4) begin
            errors++;
            $display("FAIL wrap_total: adder=%h count=%0d required 0000/4", 16'(out_sum + out_carry), out_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        send_beat(16'h1234, 1'b0);
        send_beat(16'h0011, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h00AA;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h1225 ||
                out_carry !== 16'h0020 || out_count !== 8'd2) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valid=%b in_ready=%b sum=%h carry=%h count=%0d required 1/0/1225/0020/2",
                         i, out_valid, in_ready, out_sum, out_carry, out_count);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready_edge: in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b valid=%b count=%0d required 1/0/0", in_ready, out_valid, out_count);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'h00AA || out_carry !== 16'h0 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL next_packet: valid=%b sum=%h carry=%h count=%0d required 1/00aa/0000/1",
                     out_valid, out_sum, out_carry, out_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_packet;
        bit seen_valid;
        out_ready = 1'b1;
        send_beat(16'h0100, 1'b0);
        send_beat(16'h0200, 1'b0);
        rst = 1'b1;
        seen_valid = out_valid;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_valid = seen_valid | out_valid;
        checks++;
        if (out_sum !== 16'h0 || out_carry !== 16'h0 || out_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear: sum=%h carry=%h count=%0d in_ready=%b required 0/0/0/1",
                     out_sum, out_carry, out_count, in_ready);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            seen_valid = seen_valid | out_valid;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_output: out_valid seen=%b required 0", seen_valid);
        end
        send_beat(16'd10, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || 16'(out_sum + out_carry) !== 16'd10 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL after_abort: valid=%b total=%0d count=%0d required 1/10/1",
                     out_valid, 16'(out_sum + out_carry), out_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bubbles_saturation;
        int  gaps [6];
        bit  ok;
        bit  rdy;
        gaps = '{1, 0, 2, 0, 3, 1};
        out_ready2 = 1'b1;
        for (int b = 0; b < 6; b++) begin
            in_valid2 = 1'b0;
            in_data2  = 16'hDEAD;
            in_last2  = 1'b1;
            repeat (gaps[b]) begin
                @(posedge clk);
                #1;
            end
            in_valid2 = 1'b1;
            in_data2  = 16'd1;
            in_last2  = (b == 5);
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                rdy = in_ready2;
                @(posedge clk);
                #1;
                if (rdy) ok = 1'b1;
            end
            in_valid2 = 1'b0;
            in_last2  = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sat_accept[%0d]: beat not accepted within 20 cycles", b);
            end
        end
        checks++;
        if (out_valid2 !== 1'b1 || 16'(out_sum2 + out_carry2) !== 16'd6) begin
            errors++;
            $display("FAIL sat_sum: valid=%b total=%0d required 1/6", out_valid2, 16'(out_sum2 + out_carry2));
        end
        checks++;
        if (out_count2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_count: count=%0d required 3", out_count2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_single_beat();
        test_wraparound();
        test_back_to_back();
        test_reset_mid_packet();
        test_bubbles_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
